alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle, parametrised ALU for the MIPS datapath: 1-cycle logic/arith/shift ops plus
//  iterative MULT/MULTU/DIV/DIVU producing a {hi,lo} result pair.
//  Sits between the register-read stage and write-back.
//  A valid/ready handshake lets the controller stall while a multiply or divide is in flight.
// PARAMETERS
//  WIDTH      32  operand/result width; must be >=4 and a power of 2
//  MUL_DIV_EN 1   1: MULT/DIV ops implemented; 0: those opcodes behave as illegal ops
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      op/a/b valid this cycle
//  in_ready   out  1      block can accept an op this cycle
//  alu_op     in   4      opcode (alu_pkg::alu_op_e)
//  a, b       in   WIDTH  operands; signedness set by opcode
//  out_valid  out  1      result/hi/flags valid; held until out_ready
//  out_ready  in   1      consumer takes the result
//  result     out  WIDTH  primary result; lo word for MULT/DIV (quotient for DIV)
//  hi         out  WIDTH  MULT: upper product word; DIV: remainder; other ops: 0
//  zero       out  1      result == 0
//  overflow   out  1      signed overflow on ADD/SUB; 0 for all other ops
//  busy       out  1      state is MUL or DIV or FIX
// BEHAVIOUR
//  Reset: state IDLE; out_valid, result, hi, zero, overflow, busy all 0; any in-flight op is discarded.
//  Opcodes: AND=0 OR=1 ADD=2 XOR=3 NOR=4 SLTU=5 SUB=6 SLT=7 SLL=8 SRL=9 SRA=10
//    MULT=12 MULTU=13 DIV=14 DIVU=15; code 11 is illegal -> result 0, 1-cycle.
//  Shifts: shift b by a[log2(WIDTH)-1:0]. SLT: signed compare; SLTU: unsigned; result {0..,1}/0.
//  Accept: a transfer occurs on an edge where in_valid & in_ready.
//    in_ready = (state==IDLE) | (state==DONE & out_ready).
//  FSM states: IDLE, MUL, DIV, FIX, DONE.
//    IDLE/DONE --accept 1-cycle op--> DONE, with result registered on the same edge.
//    IDLE/DONE --accept MULT*/DIV*--> MUL or DIV: operand magnitudes loaded, counter = WIDTH.
//    MUL/DIV: one shift-add (mul) or restoring-subtract (div) step per cycle, counter decrements.
//      The edge on which the counter reaches 0 moves to FIX.
//    FIX: apply sign correction for signed ops, register result/hi -> DONE.
//    DONE & out_ready & !in_valid -> IDLE. DONE & !out_ready: outputs held stable.
//  Latency from accept edge E0:
//    1-cycle ops: out_valid high after E0.
//    MUL/DIV: out_valid high after E(WIDTH+1).
//  Throughput: back-to-back 1-cycle ops run at one per clock when out_ready is held high.
//  in_valid while busy is ignored (in_ready=0); a, b, alu_op are sampled only at acceptance.
//  Arithmetic rules:
//    MULT: 2*WIDTH-bit signed product; MULTU: unsigned product.
//    DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
//    Divide by zero: quotient = all ones, remainder = a (both signed and unsigned).
//    DIV of MIN by -1: quotient = MIN, remainder = 0, overflow = 0.
//  zero is computed from the registered result and changes only when out_valid rises.
//  rst asserted in any state returns to IDLE on that edge; no output from the aborted op appears.
// STRUCTURE
//  alu_pkg (shared): alu_op_e enum (4-bit codes above), alu_state_e enum,
//    function is_muldiv(op), function is_signed(op).
//  Sub-module mul_div_iter:
//    radix-2 shift-add multiplier and restoring divider sharing one WIDTH+1 adder.
//    Ports: clk, rst, start, is_div, a_mag, b_mag, done, hi, lo.
//  alu_mc owns the handshake, the FSM, the 1-cycle ops, sign handling and the special cases.
// TESTING (WIDTH=32 unless noted)
//  1. ADD 0x7FFFFFFF+1, accept at E0 -> after E0: out_valid=1, result 0x80000000, overflow=1, zero=0.
//  2. SUB 5-5, then SLT -1<1, back-to-back with out_ready=1 -> results 0 (zero=1), then 1.
//     in_ready stays 1 throughout.
//  3. MULT -3 * 7 -> result 0xFFFFFFEB, hi 0xFFFFFFFF, out_valid after E33.
//     busy=1 from E1 to E32; in_valid during that window is ignored.
//  4. DIV -7/2 -> result -3, hi -1.
//     DIVU 7/0 -> result 0xFFFFFFFF, hi 7.
//     DIV 0x80000000/-1 -> result 0x80000000, hi 0.
//  5. Hold out_ready=0 for 5 cycles after a result -> result, hi and flags stable; in_ready=0.
//     out_ready=1 -> IDLE.
//  6. rst pulse mid-DIV (after E10) -> next cycle IDLE, out_valid=0, all outputs 0.
//     The next ADD 2+2 returns 4.
//     Repeat tests 1-4 with WIDTH=8 and MUL_DIV_EN=0: opcodes 12-15 give result 0 in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode classification helpers for the multi-cycle ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_XOR   = 4'd3,
        OP_NOR   = 4'd4,
        OP_SLTU  = 4'd5,
        OP_SUB   = 4'd6,
        OP_SLT   = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_ILL   = 4'd11,
        OP_MULT  = 4'd12,
        OP_MULTU = 4'd13,
        OP_DIV   = 4'd14,
        OP_DIVU  = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } alu_state_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed(input alu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned engine: radix-2 shift-add multiply and restoring divide, one step per clock,
// both sharing a single adder. {hi,lo} holds product, or remainder/quotient.
module mul_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = WIDTH + 2;

    logic [CW-1:0]    count_q, count_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dv_q, dv_d;

    logic [WIDTH:0]   shifted_c;
    logic [AW-1:0]    add_x_c, add_y_c, sum_c;
    logic             add_cin_c;
    logic             no_borrow_c;

    always_comb begin
        shifted_c = {hi_q, lo_q[WIDTH-1]};
        // Divide subtracts via inverted operand + carry-in; the top bit of the sum is the borrow.
        if (div_q) begin
            add_x_c   = {1'b0, shifted_c};
            add_y_c   = ~{2'b00, dv_q};
            add_cin_c = 1'b1;
        end else begin
            add_x_c   = {2'b00, hi_q};
            add_y_c   = lo_q[0] ? {2'b00, dv_q} : '0;
            add_cin_c = 1'b0;
        end
        sum_c       = add_x_c + add_y_c + AW'(add_cin_c);
        no_borrow_c = ~sum_c[AW-1];

        count_d = count_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dv_d    = dv_q;
        if (start) begin
            count_d = CW'(WIDTH);
            div_d   = is_div;
            hi_d    = '0;
            lo_d    = a_mag;
            dv_d    = b_mag;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
            if (div_q) begin
                hi_d = no_borrow_c ? sum_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], no_borrow_c};
            end else begin
                hi_d = sum_c[WIDTH:1];
                lo_d = {sum_c[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dv_q    <= '0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dv_q    <= dv_d;
        end
    end

    // High on the cycle whose edge performs the final step.
    assign done = (count_q == CW'(1));
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith/shift ops plus iterative MULT/DIV with a
// valid/ready handshake on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          MUL_DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             div0_q, div0_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;

    alu_op_e          op_in;
    logic             accept_c, md_op_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] sum_c, diff_c, sra_c;
    logic [WIDTH-1:0] fast_res_c;
    logic             fast_ovf_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic             md_start_c, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [PW-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c, rem_c, fix_res_c, fix_hi_c;

    assign op_in    = alu_op_e'(alu_op);
    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept_c = in_valid & in_ready;
    assign md_op_c  = MUL_DIV_EN && is_muldiv(op_in);

    // Single-cycle datapath; illegal and disabled mul/div opcodes fall to result 0.
    always_comb begin
        shamt_c    = a[SHW-1:0];
        sum_c      = a + b;
        diff_c     = a - b;
        sra_c      = WIDTH'($signed(b) >>> shamt_c);
        fast_res_c = '0;
        fast_ovf_c = 1'b0;
        case (op_in)
            OP_AND:  fast_res_c = a & b;
            OP_OR:   fast_res_c = a | b;
            OP_XOR:  fast_res_c = a ^ b;
            OP_NOR:  fast_res_c = ~(a | b);
            OP_ADD: begin
                fast_res_c = sum_c;
                fast_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                fast_res_c = diff_c;
                fast_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: fast_res_c = WIDTH'(a < b);
            OP_SLT:  fast_res_c = WIDTH'($signed(a) < $signed(b));
            OP_SLL:  fast_res_c = b << shamt_c;
            OP_SRL:  fast_res_c = b >> shamt_c;
            OP_SRA:  fast_res_c = sra_c;
            default: fast_res_c = '0;
        endcase
    end

    always_comb begin
        a_mag_c = a;
        b_mag_c = b;
        if (is_signed(op_in)) begin
            if (a[WIDTH-1]) a_mag_c = ~a + WIDTH'(1);
            if (b[WIDTH-1]) b_mag_c = ~b + WIDTH'(1);
        end
    end

    mul_div_iter #(.WIDTH(WIDTH)) u_mul_div_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start_c),
        .is_div (op_is_div(op_in)),
        .a_mag  (a_mag_c),
        .b_mag  (b_mag_c),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    // Sign restoration of the unsigned engine result, plus the divide-by-zero override.
    always_comb begin
        prod_c = {md_hi, md_lo};
        if (neg_lo_q) prod_c = ~prod_c + PW'(1);
        quot_c = neg_lo_q ? (~md_lo + WIDTH'(1)) : md_lo;
        rem_c  = neg_hi_q ? (~md_hi + WIDTH'(1)) : md_hi;
        if (op_is_div(op_q)) begin
            if (div0_q) begin
                fix_res_c = '1;
                fix_hi_c  = a_q;
            end else begin
                fix_res_c = quot_c;
                fix_hi_c  = rem_c;
            end
        end else begin
            fix_res_c = prod_c[WIDTH-1:0];
            fix_hi_c  = prod_c[PW-1:WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        op_d        = op_q;
        a_d         = a_q;
        div0_d      = div0_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        md_start_c  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_c) begin
                    if (md_op_c) begin
                        md_start_c  = 1'b1;
                        state_d     = op_is_div(op_in) ? ST_DIV : ST_MUL;
                        out_valid_d = 1'b0;
                        op_d        = op_in;
                        a_d         = a;
                        div0_d      = (b == '0);
                        neg_lo_d    = is_signed(op_in) & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d    = is_signed(op_in) & a[WIDTH-1];
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = fast_res_c;
                        hi_d        = '0;
                        zero_d      = (fast_res_c == '0);
                        ovf_d       = fast_ovf_c;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                result_d    = fix_res_c;
                hi_d        = fix_hi_c;
                zero_d      = (fix_res_c == '0);
                ovf_d       = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            op_q        <= OP_AND;
            a_q         <= '0;
            div0_q      <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            op_q        <= op_d;
            a_q         <= a_d;
            div0_q      <= div0_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: 32-bit instance with mul/div, plus an 8-bit instance without.
module tb_alu_mc;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] a = '0, b = '0, result, hi;
    logic        zero, overflow, busy;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8;
    logic        out_ready8 = 1'b1;
    logic [3:0]  op8 = 4'd0;
    logic [7:0]  a8 = '0, b8 = '0, result8, hi8;
    logic        zero8, overflow8, busy8;

    int   checks = 0;
    int   errors = 0;
    bit   rnd_rdy = 1'b0;
    exp_t exp_q[$];

    alu_mc #(.WIDTH(32), .MUL_DIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .hi(hi), .zero(zero), .overflow(overflow), .busy(busy)
    );

    alu_mc #(.WIDTH(8), .MUL_DIV_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .alu_op(op8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .hi(hi8), .zero(zero8), .overflow(overflow8), .busy(busy8)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the ISA rules.
    function automatic exp_t model(input int op, input longint unsigned x_in, input longint unsigned y_in,
                                   input int w, input bit md);
        exp_t e;
        longint unsigned mask, x, y, r, h, pu;
        longint sx, sy, s, p, maxs, mins;
        int sh;
        bit ov;
        mask = (64'd1 << w) - 64'd1;
        x = x_in & mask;
        y = y_in & mask;
        sx = x[w-1] ? longint'(x) - longint'(64'd1 << w) : longint'(x);
        sy = y[w-1] ? longint'(y) - longint'(64'd1 << w) : longint'(y);
        maxs = longint'((64'd1 << (w - 1)) - 64'd1);
        mins = -maxs - 1;
        sh = int'(x % longint'(w));
        r = 0; h = 0; ov = 1'b0;
        case (op)
            0:  r = x & y;
            1:  r = x | y;
            2:  begin r = (x + y) & mask; s = sx + sy; ov = (s > maxs) || (s < mins); end
            3:  r = x ^ y;
            4:  r = ~(x | y) & mask;
            5:  r = (x < y) ? 1 : 0;
            6:  begin r = (x - y) & mask; s = sx - sy; ov = (s > maxs) || (s < mins); end
            7:  r = (sx < sy) ? 1 : 0;
            8:  r = (y << sh) & mask;
            9:  r = y >> sh;
            10: begin s = sy >>> sh; r = s & mask; end
            12: if (md) begin p = sx * sy; r = p & mask; h = (p >> w) & mask; end
            13: if (md) begin pu = x * y; r = pu & mask; h = (pu >> w) & mask; end
            14: if (md) begin
                    if (y == 0) begin r = mask; h = x; end
                    else begin s = sx / sy; r = s & mask; s = sx % sy; h = s & mask; end
                end
            15: if (md) begin
                    if (y == 0) begin r = mask; h = x; end
                    else begin r = x / y; h = x % y; end
                end
            default: r = 0;
        endcase
        e.res  = r[31:0];
        e.hi   = h[31:0];
        e.zero = (r == 0);
        e.ovf  = ov;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a result is taken.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h hi %h, required no output", result, hi);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("hi", 64'(hi), 64'(e.hi));
                chk("zero", 64'(zero), 64'(e.zero));
                chk("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Present one op on the 32-bit instance, push its expectation at acceptance.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, output int waited);
        waited = 0;
        alu_op = op; a = x; b = y; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
                break;
            end
        end
        if (waited <= 200) exp_q.push_back(model(int'(op), {32'd0, x}, {32'd0, y}, 32, 1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int w;
        exp_t e;
        logic [3:0]  t_op[10];
        logic [7:0]  t_a[10];
        logic [7:0]  t_b[10];

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_flags", 64'({zero, overflow, busy}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid8", 64'({out_valid8, busy8}), 64'd0);
        @(posedge clk);
        #1;

        // ADD overflow, one-cycle latency.
        issue(4'd2, 32'h7FFF_FFFF, 32'd1, w);
        chk("add_latency_valid", 64'(out_valid), 64'd1);
        // SUB then SLT back-to-back.
        issue(4'd6, 32'd5, 32'd5, w);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, w);
        chk("b2b_in_ready_wait", 64'(w), 64'd0);
        drain();

        // MULT latency, busy window, ignored in_valid.
        issue(4'd12, 32'hFFFF_FFFD, 32'd7, w);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin alu_op = 4'd2; a = 32'd1; b = 32'd1; in_valid = 1'b1; end
            if (k == 6) in_valid = 1'b0;
            if (k == 1) chk("mult_busy_e1", 64'(busy), 64'd1);
            if (k == 4) chk("mult_in_ready_busy", 64'(in_ready), 64'd0);
            if (k == 32) chk("mult_e32_state", 64'({out_valid, busy}), 64'b01);
            if (k == 33) chk("mult_e33_state", 64'({out_valid, busy}), 64'b10);
        end
        drain();

        // Divide special cases.
        issue(4'd14, 32'hFFFF_FFF9, 32'd2, w);
        issue(4'd15, 32'd7, 32'd0, w);
        issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, w);
        issue(4'd14, 32'hFFFF_FFF9, 32'd0, w);
        drain();

        // Consumer stall: outputs held, in_ready low.
        out_ready = 1'b0;
        e = model(6, 64'd10, 64'd3, 32, 1'b1);
        issue(4'd6, 32'd10, 32'd3, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out", 64'({out_valid, in_ready}), 64'b10);
            chk("hold_result", 64'(result), 64'(e.res));
            chk("hold_hi_flags", 64'({hi, zero, overflow}), 64'({e.hi, e.zero, e.ovf}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_idle", 64'({out_valid, in_ready}), 64'b01);
        drain();

        // Reset in the middle of a divide.
        issue(4'd15, 32'd1000, 32'd7, w);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("abort_outputs", 64'({out_valid, busy, zero, overflow}), 64'd0);
        chk("abort_result_hi", {result, hi}, 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        issue(4'd2, 32'd2, 32'd2, w);
        drain();

        // Randomized traffic with a stuttering consumer.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) issue(4'($urandom_range(0, 15)), pick(), pick(), w);
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        // 8-bit instance without mul/div: back-to-back one-cycle ops.
        t_op = '{4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15, 4'd11, 4'd10, 4'd6};
        t_a  = '{8'h7F, 8'h05, 8'hFF, 8'hFD, 8'h07, 8'hF9, 8'h07, 8'h12, 8'h0B, 8'h80};
        t_b  = '{8'h01, 8'h05, 8'h01, 8'h07, 8'h07, 8'h02, 8'h00, 8'h34, 8'h90, 8'h01};
        for (int i = 0; i < 10; i++) begin
            op8 = t_op[i]; a8 = t_a[i]; b8 = t_b[i]; in_valid8 = 1'b1;
            e = model(int'(t_op[i]), {56'd0, t_a[i]}, {56'd0, t_b[i]}, 8, 1'b0);
            @(posedge clk);
            #1;
            chk("w8_valid_ready", 64'({out_valid8, in_ready8, busy8}), 64'b110);
            chk("w8_result_hi", 64'({result8, hi8}), 64'({e.res[7:0], e.hi[7:0]}));
            chk("w8_flags", 64'({zero8, overflow8}), 64'({e.zero, e.ovf}));
        end
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
